// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target predictor: entry layout,
// counter encodings and geometry derived from the entry count.
package bp_pkg;

  localparam int BP_XLEN     = 32;
  localparam int BP_ENTRIES  = 16;
  localparam int BP_CTR_BITS = 2;

  function automatic int bp_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int bp_tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  localparam int BP_IDX   = bp_idx_w(BP_ENTRIES);
  localparam int BP_TAG_W = bp_tag_w(BP_XLEN, BP_ENTRIES);

  typedef enum logic [1:0] {
    CTR_INC     = 2'd0,
    CTR_DEC     = 2'd1,
    CTR_SET_MAX = 2'd2
  } ctr_op_e;

  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_W-1:0]    tag;
    logic [BP_XLEN-1:0]     target;
    logic [BP_CTR_BITS-1:0] ctr;
  } btb_entry_t;

  function automatic logic [BP_CTR_BITS-1:0] ctr_weak_taken();
    return {1'b1, {(BP_CTR_BITS-1){1'b0}}};
  endfunction

  function automatic logic [BP_CTR_BITS-1:0] ctr_weak_not_taken();
    return {1'b0, {(BP_CTR_BITS-1){1'b1}}};
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a saturating direction counter:
// increment, decrement or force to the maximum value.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int W = 2
) (
  input  ctr_op_e      op,
  input  logic [W-1:0] ctr_i,
  output logic [W-1:0] ctr_o
);

  localparam logic [W-1:0] CTR_MAX = {W{1'b1}};
  localparam logic [W-1:0] CTR_MIN = {W{1'b0}};

  // Saturating step selected by op
  always_comb begin
    ctr_o = ctr_i;
    case (op)
      CTR_INC:     ctr_o = (ctr_i == CTR_MAX) ? ctr_i : ctr_i + W'(1);
      CTR_DEC:     ctr_o = (ctr_i == CTR_MIN) ? ctr_i : ctr_i - W'(1);
      CTR_SET_MAX: ctr_o = CTR_MAX;
      default:     ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, combinational lookup, registered update and statistics.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int XLEN      = BP_XLEN,
  parameter int ENTRIES   = BP_ENTRIES,
  parameter int CTR_BITS  = BP_CTR_BITS,
  parameter int STAT_BITS = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  input  logic                 upd_valid,
  input  logic [XLEN-1:0]      upd_pc,
  input  logic                 upd_is_jump,
  input  logic                 upd_taken,
  input  logic [XLEN-1:0]      upd_target,
  input  logic                 upd_mispredict,
  input  logic                 flush,
  output logic [STAT_BITS-1:0] stat_updates,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int IDX   = bp_idx_w(ENTRIES);
  localparam int TAG_W = bp_tag_w(XLEN, ENTRIES);

  btb_entry_t entries_q [ENTRIES];
  btb_entry_t entries_d [ENTRIES];
  logic [STAT_BITS-1:0] stat_updates_q, stat_updates_d;
  logic [STAT_BITS-1:0] stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX-1:0]   if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             if_hit, upd_hit;
  ctr_op_e          ctr_op;
  logic [CTR_BITS-1:0] ctr_next;
  logic             unused_pc_bits;

  assign if_idx  = if_pc[IDX+1:2];
  assign if_tag  = if_pc[XLEN-1:IDX+2];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX+2];
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup reads pre-update state; there is deliberately no bypass
  always_comb begin
    if_hit      = entries_q[if_idx].valid && (entries_q[if_idx].tag == if_tag);
    pred_taken  = if_hit && entries_q[if_idx].ctr[CTR_BITS-1];
    pred_target = pred_taken ? entries_q[if_idx].target : if_pc + XLEN'(4);
  end

  always_comb begin
    upd_hit = entries_q[upd_idx].valid && (entries_q[upd_idx].tag == upd_tag);
    if (upd_is_jump) begin
      ctr_op = CTR_SET_MAX;
    end else if (upd_taken) begin
      ctr_op = CTR_INC;
    end else begin
      ctr_op = CTR_DEC;
    end
  end

  bp_sat_counter #(.W(CTR_BITS)) u_sat_counter (
    .op    (ctr_op),
    .ctr_i (entries_q[upd_idx].ctr),
    .ctr_o (ctr_next)
  );

  // Entry and statistics next state; flush drops the entry write but not the counts
  always_comb begin
    entries_d          = entries_q;
    stat_updates_d     = stat_updates_q + STAT_BITS'(upd_valid);
    stat_mispredicts_d = stat_mispredicts_q + STAT_BITS'(upd_valid & upd_mispredict);
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_d[i].valid = 1'b0;
      end
    end else if (upd_valid && upd_hit) begin
      entries_d[upd_idx].ctr = ctr_next;
      if (upd_taken || upd_is_jump) begin
        entries_d[upd_idx].target = upd_target;
      end else begin
        entries_d[upd_idx].target = entries_q[upd_idx].target;
      end
    end else if (upd_valid && (upd_taken || upd_is_jump)) begin
      entries_d[upd_idx].valid  = 1'b1;
      entries_d[upd_idx].tag    = upd_tag;
      entries_d[upd_idx].target = upd_target;
      entries_d[upd_idx].ctr    = upd_is_jump ? {CTR_BITS{1'b1}} : ctr_weak_taken();
    end else begin
      entries_d[upd_idx] = entries_q[upd_idx];
    end
  end

  // State registers; reset discards everything presented in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i].valid  <= 1'b0;
        entries_q[i].tag    <= {TAG_W{1'b0}};
        entries_q[i].target <= {XLEN{1'b0}};
        entries_q[i].ctr    <= ctr_weak_not_taken();
      end
      stat_updates_q     <= {STAT_BITS{1'b0}};
      stat_mispredicts_q <= {STAT_BITS{1'b0}};
    end else begin
      entries_q          <= entries_d;
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor with hand-computed expectations.
module tb_branch_target_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        flush;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;

  int vec_cnt = 0;
  int err_cnt = 0;

  branch_target_predictor dut (
    .clock            (clock),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_is_jump      (upd_is_jump),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .flush            (flush),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic jump, input logic taken,
                     input logic [31:0] target, input logic mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_is_jump    = jump;
    upd_taken      = taken;
    upd_target     = target;
    upd_mispredict = mis;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                      input logic [31:0] exp_target);
    if_pc = pc;
    #1;
    check_eq({tag, "_taken"}, 64'(pred_taken), 64'(exp_taken));
    check_eq({tag, "_target"}, 64'(pred_target), 64'(exp_target));
  endtask

  task automatic stats(input string tag, input logic [31:0] exp_upd, input logic [31:0] exp_mis);
    check_eq({tag, "_upd"}, 64'(stat_updates), 64'(exp_upd));
    check_eq({tag, "_mis"}, 64'(stat_mispredicts), 64'(exp_mis));
  endtask

  initial begin
    reset = 1'b1; if_pc = 32'h40; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = 32'h0;
    upd_mispredict = 1'b0; flush = 1'b0;
    tick(); tick();
    look("in_reset", 32'h40, 1'b0, 32'h44);
    reset = 1'b0;
    tick();
    look("reset", 32'h40, 1'b0, 32'h44);
    stats("reset", 32'd0, 32'd0);

    // taken branch allocates weakly-taken
    upd(32'h10, 1'b0, 1'b1, 32'h20, 1'b0);
    look("alloc", 32'h10, 1'b1, 32'h20);
    stats("alloc", 32'd1, 32'd0);

    // counter walks down, saturates at 0, walks back up
    upd(32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    look("nt1", 32'h10, 1'b0, 32'h14);
    upd(32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    upd(32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    look("nt_sat", 32'h10, 1'b0, 32'h14);
    upd(32'h10, 1'b0, 1'b1, 32'h20, 1'b0);
    look("t01", 32'h10, 1'b0, 32'h14);
    upd(32'h10, 1'b0, 1'b1, 32'h20, 1'b0);
    look("t10", 32'h10, 1'b1, 32'h20);
    upd(32'h10, 1'b0, 1'b1, 32'h20, 1'b0);
    upd(32'h10, 1'b0, 1'b1, 32'h20, 1'b0);
    upd(32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    look("top_sat", 32'h10, 1'b1, 32'h20);
    upd(32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    look("down01", 32'h10, 1'b0, 32'h14);
    upd(32'h10, 1'b0, 1'b1, 32'h24, 1'b0);
    look("retarget", 32'h10, 1'b1, 32'h24);
    stats("counter", 32'd11, 32'd0);

    // alias at index 4 replaces the entry
    upd(32'h50, 1'b0, 1'b1, 32'h80, 1'b0);
    look("alias_new", 32'h50, 1'b1, 32'h80);
    look("alias_old", 32'h10, 1'b0, 32'h14);

    // not-taken miss must not allocate
    upd(32'h60, 1'b0, 1'b0, 32'h99, 1'b0);
    look("nt_miss", 32'h60, 1'b0, 32'h64);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    stats("alias", 32'd13, 32'd0);

    // jump with same-cycle lookup sees pre-update state
    if_pc = 32'h30; upd_valid = 1'b1; upd_pc = 32'h30; upd_is_jump = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h40; upd_mispredict = 1'b1;
    look("jump_same", 32'h30, 1'b0, 32'h34);
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0; upd_is_jump = 1'b0;
    look("jump_next", 32'h30, 1'b1, 32'h40);
    stats("jump", 32'd14, 32'd1);
    upd(32'h30, 1'b0, 1'b0, 32'h0, 1'b0);
    look("jump_ctr11", 32'h30, 1'b1, 32'h40);
    upd(32'h30, 1'b0, 1'b0, 32'h0, 1'b0);
    look("jump_ctr01", 32'h30, 1'b0, 32'h34);

    // flush beats a simultaneous update but the update is still counted
    flush = 1'b1;
    upd(32'h18, 1'b0, 1'b1, 32'h100, 1'b0);
    flush = 1'b0;
    look("flush_18", 32'h18, 1'b0, 32'h1C);
    look("flush_50", 32'h50, 1'b0, 32'h54);
    look("flush_30", 32'h30, 1'b0, 32'h34);
    stats("flush", 32'd17, 32'd1);

    // reset mid-run with an update pending
    upd(32'h10, 1'b0, 1'b1, 32'h20, 1'b0);
    look("realloc", 32'h10, 1'b1, 32'h20);
    reset = 1'b1;
    upd(32'h70, 1'b0, 1'b1, 32'h200, 1'b1);
    stats("in_reset2", 32'd0, 32'd0);
    reset = 1'b0;
    tick();
    look("rst_10", 32'h10, 1'b0, 32'h14);
    look("rst_70", 32'h70, 1'b0, 32'h74);
    stats("reset2", 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with per-entry saturating direction counters. It lets the pipelined RISCVCPU redirect fetch speculatively on branches and jumps instead of always predicting fall-through. It sits beside `if_stage`:

- **Lookup:** combinational, from the current fetch PC.
- **Update:** registered, from the EX stage once a branch or jump resolves.
- **Counters:** two performance counters for update and misprediction rates.

## Interface
Parameters:
- `XLEN`, 32: PC and target width.
- `ENTRIES`, 16: BTB entries. Power of two, at least 2. `IDX = $clog2(ENTRIES)`.
- `CTR_BITS`, 2: direction counter width, 2 to 4.
- `STAT_BITS`, 32: performance counter width.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `if_pc` in XLEN: fetch PC to predict.
- `pred_taken` out 1: predicted redirect.
- `pred_target` out XLEN: next fetch PC.
- `upd_valid` in 1: a resolved control-flow instruction is present this cycle.
- `upd_pc` in XLEN: PC of the resolved instruction.
- `upd_is_jump` in 1: instruction is `jal`/`jalr`, i.e. unconditional.
- `upd_taken` in 1: actual outcome. Must be 1 when `upd_is_jump`.
- `upd_target` in XLEN: actual taken target.
- `upd_mispredict` in 1: EX detected a misprediction; counted only.
- `flush` in 1: invalidate all entries, e.g. for `fence.i`.
- `stat_updates` out STAT_BITS: accepted updates.
- `stat_mispredicts` out STAT_BITS: updates with `upd_mispredict`.

## Operation
Indexing and entry contents:
- `index = pc[IDX+1:2]`.
- `tag = pc[XLEN-1:IDX+2]`. `pc[1:0]` is ignored.
- Each entry holds `valid`, `tag`, `target` (XLEN) and `ctr` (CTR_BITS).
- A hit means `valid` is set and the stored tag equals the `if_pc` tag.

Lookup (combinational):
- `pred_taken = hit & ctr[CTR_BITS-1]`.
- `pred_target` is the stored target when `pred_taken`, otherwise `if_pc + 4` (modulo 2^XLEN).

Update when `upd_valid` is high and `upd_pc` hits:
- Jump: `ctr` is set to all-ones and `target` is overwritten.
- Conditional branch, taken: `ctr` increments, saturating at all-ones, and `target` is overwritten.
- Conditional branch, not taken: `ctr` decrements, saturating at 0, and `target` is unchanged.

Update when `upd_valid` is high and `upd_pc` misses:
- Taken or jump: allocate the entry, replacing any aliasing entry. Write `valid=1`, the new tag and target.
  - `ctr` = all-ones for a jump.
  - `ctr` = weakly-taken (`1` followed by zeros) for a branch.
- Not taken: no allocation and no state change.

Statistics:
- `stat_updates` increments on each `upd_valid`.
- `stat_mispredicts` increments on each `upd_valid & upd_mispredict`.
- Both wrap modulo 2^STAT_BITS.

Flush:
- `flush` clears every `valid` bit. `tag`, `target` and `ctr` are don't-care.
- `flush` wins over a simultaneous update: that update's entry write is dropped, but the statistics still count it.

## Timing
- Lookup has zero latency: combinational from `if_pc` and the entry registers.
- Updates and flush take effect at the next rising edge and are visible to lookups from the following cycle.
- A lookup and an update to the same index in the same cycle: the lookup returns pre-update state. There is no bypass.

Reset:
- Clears all `valid` bits.
- Sets every `ctr` to weakly-not-taken (`0` followed by ones).
- Zeroes both statistics counters.

Outputs during and immediately after reset:
- `pred_taken = 0`.
- `pred_target = if_pc + 4`.
- Statistics read 0.

Reset behaviour:
- Updates and flush presented while `reset` is high are ignored entirely, statistics included.
- Asserting reset mid-sequence discards all learned state in one cycle.

Entries are flop arrays, not SRAM. All entries clear in a single cycle.

## Structure
- Package `bp_pkg` holds:
  - the `btb_entry_t` struct (`valid`, `tag`, `target`, `ctr`);
  - the functions `ctr_weak_taken` and `ctr_weak_not_taken`;
  - the localparam helpers for `IDX` and tag width.
- Sub-module `bp_sat_counter` is instanced inside the update path. It is purely combinational next-state logic: inc, dec or set-max, saturating, width CTR_BITS.
- The top module holds the entry array, the lookup and allocation logic, and the statistics counters.

## Test plan
All scenarios use the default parameters.

1. **Reset state:** after reset, lookup 0x40 gives `pred_taken=0`, `pred_target=0x44`, and both statistics read 0.
2. **Taken branch allocation:** update pc=0x10 as a taken branch with target 0x20. The next cycle, lookup 0x10 gives `pred_taken=1`, target 0x20 (ctr=2'b10). `stat_updates=1`.
3. **Saturating counter:**
   - Two not-taken updates at 0x10 bring ctr to 00, and lookup gives not-taken, target 0x14.
   - One taken update brings ctr to 01, still not-taken.
   - A second taken update brings ctr to 10, and lookup predicts 0x20.
4. **Alias replacement:** 0x50 shares index 4 with 0x10. A taken update at 0x50 with target 0x80 allocates the entry. Lookup 0x50 predicts 0x80, and lookup 0x10 now misses (target 0x14).
5. **Jump, same-cycle lookup:** `jalr` at 0x30 with target 0x40 and `upd_mispredict=1`, with lookup 0x30 in the same cycle.
   - Same cycle: the lookup misses.
   - Next cycle: hit, predict 0x40, ctr=11.
   - `stat_mispredicts=1`.
6. **Flush and reset:**
   - `flush` together with a taken update at 0x18: every lookup misses afterwards, and `stat_updates` is incremented.
   - Reset asserted mid-run with `upd_valid` high: statistics read 0 and nothing is allocated.
